// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time game: fsm state encodings,
// option bit positions and the 16-bit LFSR used for the random foreperiod.
package reaction_pkg;

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b111,
    S5 = 3'b110
  } fsm_state_t;

  localparam int unsigned OPT_START = 3;
  localparam int unsigned OPT_REACT = 2;
  localparam int unsigned OPT_RAND  = 1;
  localparam int unsigned OPT_TOUT  = 0;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rt_tick_gen.sv
// Tick prescaler: one-cycle pulse every DIV clocks; clear restarts a full period.
module rt_tick_gen #(
  parameter int unsigned DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt <= '0;
    else if (clear || cnt == LAST)  cnt <= '0;
    else                            cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/reaction_round_ctrl.sv
// Sequencer/timing engine feeding the reaction-game fsm: option pulses, random
// foreperiod, reaction counter, round count. AUTO_FINISH_EN selects auto session end.
module reaction_round_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int unsigned RAND_MIN   = 1000,
  parameter int unsigned RAND_BITS  = 11,
  parameter int unsigned TIMEOUT    = 2000,
  parameter int unsigned MAX_ROUNDS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        react_btn,
  input  logic        finish_btn,
  input  logic        mode,
  input  logic [2:0]  state,
  output logic [3:0]  option,
  output logic [15:0] act_time,
  output logic        finish_test,
  output logic [3:0]  round_cnt
);

  localparam logic [15:0] RAND_MASK = 16'((32'd1 << RAND_BITS) - 32'd1);
  localparam logic [15:0] RAND_BASE = 16'(RAND_MIN);
  localparam logic [15:0] TOUT_THR  = 16'(TIMEOUT);

  if (MAX_ROUNDS == 0 || MAX_ROUNDS > 15 || RAND_MIN == 0) begin : g_param_check
    $error("reaction_round_ctrl: MAX_ROUNDS must be 1..15 and RAND_MIN nonzero");
  end

  logic [2:0]  state_q;
  logic        state_chg;
  logic        entry_s1, entry_s3, entry_s4, entry_s5;
  logic        in_s1, in_s3;
  logic        tick;
  logic        start_prev, react_prev;
  logic        start_edge, react_edge;
  logic        start_pulse, react_pulse, rand_pulse, tout;
  logic [15:0] lfsr;
  logic [15:0] delay_cnt;
  logic [15:0] act_cnt;
  logic [3:0]  rounds, round_next;
  logic        fin_q;

  assign state_chg  = (state != state_q);
  assign entry_s1   = (state == S1) && (state_q != S1);
  assign entry_s3   = (state == S3) && (state_q != S3);
  assign entry_s4   = (state == S4) && (state_q != S4);
  assign entry_s5   = (state == S5) && (state_q != S5);
  assign in_s1      = (state == S1) && !state_chg;
  assign in_s3      = (state == S3) && !state_chg;
  assign start_edge = start_btn && !start_prev;
  assign react_edge = react_btn && !react_prev;

  rt_tick_gen #(
    .DIV (CLK_HZ / TICK_HZ)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state_chg),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S0;
      start_prev  <= 1'b0;
      react_prev  <= 1'b0;
      start_pulse <= 1'b0;
      react_pulse <= 1'b0;
      lfsr        <= LFSR_SEED;
    end else begin
      state_q     <= state;
      start_prev  <= start_btn;
      react_prev  <= react_btn;
      start_pulse <= start_edge;
      react_pulse <= react_edge;
      lfsr        <= lfsr_next(lfsr);
    end
  end

  // Delay parks at zero after the pulse, so a long stay in S1 cannot re-fire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_cnt  <= '0;
      rand_pulse <= 1'b0;
    end else begin
      rand_pulse <= in_s1 && tick && (delay_cnt == 16'd1);
      if (entry_s1)
        delay_cnt <= RAND_BASE + (lfsr & RAND_MASK);
      else if (in_s1 && tick && delay_cnt != '0)
        delay_cnt <= delay_cnt - 16'd1;
    end
  end

  // A press freezes the count both in its edge cycle and in the pulse cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      act_cnt <= '0;
    else if (entry_s3)
      act_cnt <= '0;
    else if (in_s3 && tick && !react_edge && !react_pulse && act_cnt != '1)
      act_cnt <= act_cnt + 16'd1;
  end

  assign tout = (state_q == S3) && (act_cnt >= TOUT_THR);

  always_comb begin
    round_next = rounds;
    if (!mode || entry_s5)
      round_next = '0;
    else if (entry_s4 && rounds != '1)
      round_next = rounds + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rounds <= '0;
    else     rounds <= round_next;
  end

`ifdef AUTO_FINISH_EN
  localparam logic [3:0] ROUND_LIM = 4'(MAX_ROUNDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fin_q <= 1'b0;
    else     fin_q <= mode && (state == S4) && (round_next >= ROUND_LIM);
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fin_q <= 1'b0;
    else     fin_q <= finish_btn;
  end
`endif

  always_comb begin
    option            = '0;
    option[OPT_START] = start_pulse;
    option[OPT_REACT] = react_pulse;
    option[OPT_RAND]  = rand_pulse;
    option[OPT_TOUT]  = tout;
  end

  assign act_time    = act_cnt;
  assign finish_test = fin_q;
  assign round_cnt   = rounds;

endmodule
